// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle controller.
// Holds the FSM state enum, opcode classes and datapath select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } mc_state_t;

    // IR[31:12] as seen by the controller
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rn;
        logic [3:0] rd;
    } mc_instr_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Data-processing cmd field to ALU operation; unknown cmds add.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            4'b0100: alu_decode = ALU_ADD;
            4'b0010: alu_decode = ALU_SUB;
            4'b0000: alu_decode = ALU_AND;
            4'b1100: alu_decode = ALU_ORR;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_condcheck.sv
// mc_condcheck: ARM condition-code evaluation against a stored NZCV.
// Purely combinational; code 1111 never executes.
module mc_condcheck (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Standard ARM condition table
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = ~(n ^ v);
            4'b1011: cond_ex = n ^ v;
            4'b1100: cond_ex = ~z & ~(n ^ v);
            4'b1101: cond_ex = z | (n ^ v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle FSM sequencer for the ARMv4-subset datapath.
// Optional MC_CTRL_MEMWAIT_EN stalls FETCH/MEMRD/MEMWR on mem_ready.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [1:0]  alu_control
);

    mc_instr_t ir;
    assign ir = instr;

    logic mem_rdy;
`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_rdy = mem_ready;
    logic unused_ok;
    assign unused_ok = ^ir.rn;
`else
    assign mem_rdy = 1'b1;
    logic unused_ok;
    assign unused_ok = ^{mem_ready, ir.rn};
`endif

    mc_state_t  state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;
    logic       cond_ex;

    logic irw, fetch_pc, regw, memw, branch, alu_op;

    mc_condcheck u_cond (
        .cond    (ir.cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    // State, flags and latched condition; reset restarts at FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // Next-state and raw per-state controls
    always_comb begin
        state_d    = state_q;
        adr_src    = 1'b0;
        irw        = 1'b0;
        fetch_pc   = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RD2;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_rdy) begin
                    irw      = 1'b1;
                    fetch_pc = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                case (ir.op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = ir.funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = ir.funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                regw       = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                memw    = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_b = SRCB_RD2;
                alu_op    = 1'b1;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                regw       = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU op, flag update and condition latch
    always_comb begin
        alu_control = alu_op ? alu_decode(ir.funct[4:1]) : ALU_ADD;
        flags_d     = flags_q;
        cond_ex_d   = cond_ex_q;
        if (alu_op && ir.funct[0] && cond_ex) begin
            flags_d[3:2] = alu_flags[3:2];
            if (alu_control == ALU_ADD || alu_control == ALU_SUB)
                flags_d[1:0] = alu_flags[1:0];
        end
        if (state_q == S_DECODE || state_q == S_EXECR ||
            state_q == S_EXECI || state_q == S_MEMADR)
            cond_ex_d = cond_ex;
    end

    assign imm_src = ir.op;
    assign reg_src = {ir.op == OP_MEM, ir.op == OP_BR};

    assign ir_write  = ~reset & irw;
    assign reg_write = ~reset & regw & cond_ex_q;
    assign mem_write = ~reset & memw & cond_ex_q;
    assign pc_write  = ~reset & (fetch_pc |
                       ((branch | (regw & (ir.rd == 4'hF))) & cond_ex_q));

endmodule
